ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port main-memory RAM between N_REQ requesters, e.g. CPU fetch/execute and an I/O DMA channel.
- Round-robin arbitration with a request/grant/done handshake.
- Owns all RAM control: drives address, data, read_enable and write_enable, and registers read data.
- A lock input gives an owner atomic read-modify-write sequences, such as the ISZ instruction.

Parameters:
D_WIDTH, 16, data word width in bits.
A_WIDTH, 12, RAM address width.
N_REQ, 2, number of requesters (2..8).
LOCK_MAX, 15, maximum idle cycles an owner may hold a lock before forced release.

Ports:
clock  input  1  system clock, rising edge.
reset_n_in  input  1  asynchronous, active-low reset.
req_in  input  N_REQ  per-requester access request.
write_in  input  N_REQ  per-requester operation select: 1 = write, 0 = read.
lock_in  input  N_REQ  per-requester keep-grant request.
address_in  input  N_REQ x A_WIDTH  per-requester word address.
data_in  input  N_REQ x D_WIDTH  per-requester write data.
grant_out  output  N_REQ  one-hot current owner; all zero when unowned.
done_out  output  1  one-cycle pulse: owner's access completed.
data_out  output  D_WIDTH  registered read data of the last read.
lock_timeout_out  output  1  one-cycle pulse: lock forcibly released.
ram_address_out  output  A_WIDTH  to RAM address_in.
ram_data_out  output  D_WIDTH  to RAM data_in.
ram_read_enable_out  output  1  to RAM read_enable_in.
ram_write_enable_out  output  1  to RAM write_enable_in.

Behaviour:
- States: IDLE, ACCESS, DONE, LOCKED.
- Reset (async, reset_n_in low):
  - state = IDLE, grant_out = 0, done_out = 0, lock_timeout_out = 0, data_out = 0.
  - RR pointer = N_REQ-1, so requester 0 wins first.
  - Lock counter = 0.
  - RAM enables are decoded from state, so reset during ACCESS suppresses that cycle's write.
- IDLE:
  - If any req_in is set, pick the first set bit searching from pointer+1 with wrap-around.
  - Register the pick into grant_out and the pointer; next state ACCESS.
  - If no request, stay in IDLE with grant_out = 0.
- ACCESS (exactly 1 cycle):
  - ram_address_out and ram_data_out are muxed from the owner.
  - ram_read_enable_out = !write_in[owner]; ram_write_enable_out = write_in[owner].
  - On read, data_out <= RAM data at the closing edge.
  - On write, the RAM commits at the same edge; data_out is unchanged.
  - Next state DONE.
- DONE (1 cycle):
  - done_out = 1 and grant_out is held.
  - Next state LOCKED if lock_in[owner] = 1, else IDLE with grant_out cleared.
- LOCKED:
  - grant_out is held; other requesters are ignored.
  - req_in[owner] = 1 → ACCESS next cycle, lock counter cleared.
  - lock_in[owner] = 0 with no request → IDLE, grant cleared.
  - Otherwise the counter increments. At LOCK_MAX → IDLE, grant cleared, lock_timeout_out pulses 1 cycle.
- Outside ACCESS, RAM enables are 0 and ram_address_out/ram_data_out hold the owner's values (0 when unowned).
- Requester contract:
  - Hold address/write/data stable from req until done.
  - Drop req in the DONE cycle unless it has another access queued.
  - A request that is still high in the IDLE cycle after DONE re-enters arbitration normally.
- Latency and throughput:
  - Uncontended: req high at edge k → grant visible after edge k+1 → done_out high after edge k+2 → data_out valid with done_out.
  - Throughput is 1 access per 3 cycles; locked back-to-back accesses take 3 cycles each (LOCKED→ACCESS→DONE).
- Requests arriving during ACCESS/DONE/LOCKED wait; no request is lost while req stays high.
- Fairness: every requester is served within N_REQ grants, excluding lock hold time.

Decomposition:
- Package ram_arbiter_pkg holds:
  - state enum type ram_arb_state_t {IDLE, ACCESS, DONE, LOCKED};
  - lock counter width function clog2(LOCK_MAX+1).
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and a valid flag.
  - Instantiated once.

Test Plan:
- Single read: after reset, req0 read addr 12'h0A5, RAM preloaded with 16'h1234 → grant_out = 01 at cycle 1, ram_read_enable_out = 1 at cycle 1, done_out at cycle 2, data_out = 16'h1234.
- Contention: req0 and req1 both high continuously → grants alternate 01,10,01,10 over 4 accesses, each done_out 3 cycles apart.
- Write then read: req1 writes 16'hBEEF to 12'hFFF, then req0 reads 12'hFFF → data_out = 16'hBEEF; ram_write_enable_out high for exactly 1 cycle.
- Locked RMW:
  - Stimulus: req0 reads 12'h010 (16'h0007) with lock_in0 = 1, req1 pending throughout.
  - Required: after DONE, state LOCKED with grant held; req0 write 16'h0008 completes before grant_out ever shows 10; RAM[12'h010] = 16'h0008.
- Lock timeout: owner holds lock_in = 1 and req = 0 for LOCK_MAX cycles → lock_timeout_out pulses once, grant passes to pending req1.
- Reset mid-write: reset_n_in low during ACCESS of a write to 12'h020 → ram_write_enable_out drops immediately, RAM[12'h020] unchanged, all outputs at reset values.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared types and helpers for the main-memory RAM arbiter.
//   ram_arb_state_t : arbiter FSM states
//   clog2()         : ceiling log2 (minimum result 1), usable in parameters
//   lock_cnt_width(): width of the lock idle counter for a given LOCK_MAX
// ----------------------------------------------------------------------------
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    LOCKED = 2'd3
  } ram_arb_state_t;

  // Ceiling log2 that never returns 0, so it can size a vector directly.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // The counter must be able to hold every value 0..LOCK_MAX.
  function automatic int lock_cnt_width(input int lock_max);
    return clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the request vector starting
// one position after the pointer (the last winner), wrapping around, and
// returns the first set bit as a one-hot grant.
// Ports:
//   req_in    : request vector
//   ptr_in    : index of the previous winner
//   grant_out : one-hot pick (all zero when nothing is requested)
//   valid_out : 1 when grant_out holds a pick
// ----------------------------------------------------------------------------
module rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req_in,
  input  logic [PTR_W-1:0] ptr_in,
  output logic [N-1:0]     grant_out,
  output logic             valid_out
);

  // Visit ptr+1, ptr+2, ... ptr+N (mod N); ptr itself is visited last so the
  // previous winner has the lowest priority.
  always_comb begin
    int idx;
    grant_out = '0;
    valid_out = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_in) + i) % N;
      if (!valid_out && req_in[idx]) begin
        grant_out[idx] = 1'b1;
        valid_out      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
// Shares the single-port main-memory RAM between N_REQ requesters using a
// round-robin request/grant/done handshake. The arbiter owns all RAM control
// and registers read data. An owner may keep the grant between accesses with
// lock_in (atomic read-modify-write); an idle lock is forcibly released after
// LOCK_MAX cycles.
// Ports:
//   clock, reset_n_in     : clock (rising edge), async active-low reset
//   req_in/write_in/lock_in : per-requester request, write select, keep-grant
//   address_in/data_in    : per-requester word address and write data
//   grant_out             : one-hot owner, zero when unowned
//   done_out              : one-cycle pulse, owner's access completed
//   data_out              : registered read data of the last read
//   lock_timeout_out      : one-cycle pulse, lock forcibly released
//   ram_*_out             : RAM address, write data, read/write enables
//   ram_data_in           : RAM asynchronous read data
// ----------------------------------------------------------------------------
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int D_WIDTH  = 16,
  parameter int A_WIDTH  = 12,
  parameter int N_REQ    = 2,
  parameter int LOCK_MAX = 15
) (
  input  logic                            clock,
  input  logic                            reset_n_in,
  input  logic [N_REQ-1:0]                req_in,
  input  logic [N_REQ-1:0]                write_in,
  input  logic [N_REQ-1:0]                lock_in,
  input  logic [N_REQ-1:0][A_WIDTH-1:0]   address_in,
  input  logic [N_REQ-1:0][D_WIDTH-1:0]   data_in,
  output logic [N_REQ-1:0]                grant_out,
  output logic                            done_out,
  output logic [D_WIDTH-1:0]              data_out,
  output logic                            lock_timeout_out,
  output logic [A_WIDTH-1:0]              ram_address_out,
  output logic [D_WIDTH-1:0]              ram_data_out,
  output logic                            ram_read_enable_out,
  output logic                            ram_write_enable_out,
  input  logic [D_WIDTH-1:0]              ram_data_in
);

  localparam int PTR_W  = clog2(N_REQ);
  localparam int LOCK_W = lock_cnt_width(LOCK_MAX);

  ram_arb_state_t      state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                lock_timeout_q, lock_timeout_d;
  logic [D_WIDTH-1:0]  data_q, data_d;

  logic [N_REQ-1:0]    pick_grant;
  logic                pick_valid;
  logic [PTR_W-1:0]    pick_idx;
  logic                owned;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_in    (req_in),
    .ptr_in    (ptr_q),
    .grant_out (pick_grant),
    .valid_out (pick_valid)
  );

  // One-hot to index; the pointer doubles as the owner index while granted.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  // Next-state logic. Grant and pointer only change in IDLE, so ptr_q always
  // names the current owner while grant_q is non-zero.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    ptr_d          = ptr_q;
    lock_cnt_d     = lock_cnt_q;
    lock_timeout_d = 1'b0;
    data_d         = data_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d = pick_grant;
          ptr_d   = pick_idx;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!write_in[ptr_q]) begin
          data_d = ram_data_in;
        end
        state_d = DONE;
      end
      DONE: begin
        lock_cnt_d = '0;
        if (lock_in[ptr_q]) begin
          state_d = LOCKED;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      LOCKED: begin
        if (req_in[ptr_q]) begin
          state_d    = ACCESS;
          lock_cnt_d = '0;
        end else if (!lock_in[ptr_q]) begin
          state_d    = IDLE;
          grant_d    = '0;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_W'(LOCK_MAX - 1)) begin
          // This is the LOCK_MAX-th idle cycle held under lock.
          state_d        = IDLE;
          grant_d        = '0;
          lock_cnt_d     = '0;
          lock_timeout_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; the pointer resets to the last requester so requester 0
  // wins the first arbitration.
  always_ff @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      ptr_q          <= PTR_W'(N_REQ - 1);
      lock_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      ptr_q          <= ptr_d;
      lock_cnt_q     <= lock_cnt_d;
      lock_timeout_q <= lock_timeout_d;
      data_q         <= data_d;
    end
  end

  // RAM enables are decoded from the state register so an async reset during
  // ACCESS removes the enable before the closing edge.
  always_comb begin
    owned                = |grant_q;
    ram_address_out      = '0;
    ram_data_out         = '0;
    ram_read_enable_out  = 1'b0;
    ram_write_enable_out = 1'b0;
    if (owned) begin
      ram_address_out = address_in[ptr_q];
      ram_data_out    = data_in[ptr_q];
    end
    if (state_q == ACCESS) begin
      ram_read_enable_out  = !write_in[ptr_q];
      ram_write_enable_out = write_in[ptr_q];
    end
  end

  assign grant_out        = grant_q;
  assign done_out         = (state_q == DONE);
  assign data_out         = data_q;
  assign lock_timeout_out = lock_timeout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
// Directed self-checking bench for ram_arbiter with a behavioural RAM
// (asynchronous read, write on the rising edge when write enable is high).
// ----------------------------------------------------------------------------
module tb_ram_arbiter;

  logic              clock;
  logic              reset_n_in;
  logic [1:0]        req_in;
  logic [1:0]        write_in;
  logic [1:0]        lock_in;
  logic [1:0][11:0]  address_in;
  logic [1:0][15:0]  data_in;
  logic [1:0]        grant_out;
  logic              done_out;
  logic [15:0]       data_out;
  logic              lock_timeout_out;
  logic [11:0]       ram_address_out;
  logic [15:0]       ram_data_out;
  logic              ram_read_enable_out;
  logic              ram_write_enable_out;
  logic [15:0]       ram_data_in;

  logic [15:0]       mem [0:4095];
  int                wen_total;
  int                check_cnt;
  int                pass_cnt;

  ram_arbiter #(
    .D_WIDTH  (16),
    .A_WIDTH  (12),
    .N_REQ    (2),
    .LOCK_MAX (15)
  ) dut (
    .clock                (clock),
    .reset_n_in           (reset_n_in),
    .req_in               (req_in),
    .write_in             (write_in),
    .lock_in              (lock_in),
    .address_in           (address_in),
    .data_in              (data_in),
    .grant_out            (grant_out),
    .done_out             (done_out),
    .data_out             (data_out),
    .lock_timeout_out     (lock_timeout_out),
    .ram_address_out      (ram_address_out),
    .ram_data_out         (ram_data_out),
    .ram_read_enable_out  (ram_read_enable_out),
    .ram_write_enable_out (ram_write_enable_out),
    .ram_data_in          (ram_data_in)
  );

  // 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural RAM plus a running count of write-enable cycles.
  assign ram_data_in = mem[ram_address_out];

  always @(posedge clock) begin
    if (ram_write_enable_out) begin
      mem[ram_address_out] <= ram_data_out;
      wen_total <= wen_total + 1;
    end
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req_in     = '0;
    write_in   = '0;
    lock_in    = '0;
    address_in = '0;
    data_in    = '0;
    reset_n_in = 1'b0;
    tick();
    tick();
    reset_n_in = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req_in     = '0;
    address_in[0] = 12'h123;
    reset_n_in = 1'b0;
    #3;
    check_cnt++;
    if (grant_out !== 2'b00 || done_out !== 1'b0 || lock_timeout_out !== 1'b0 ||
        data_out !== 16'h0000)
      $display("[TB] FAIL reset_outputs got grant=%b done=%b to=%b data=%h want 00 0 0 0000",
               grant_out, done_out, lock_timeout_out, data_out);
    else pass_cnt++;
    check_cnt++;
    if (ram_read_enable_out !== 1'b0 || ram_write_enable_out !== 1'b0 ||
        ram_address_out !== 12'h000)
      $display("[TB] FAIL reset_ram got ren=%b wen=%b addr=%h want 0 0 000",
               ram_read_enable_out, ram_write_enable_out, ram_address_out);
    else pass_cnt++;
    tick();
    reset_n_in = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    mem[12'h0A5]  = 16'h1234;
    address_in[0] = 12'h0A5;
    write_in[0]   = 1'b0;
    req_in[0]     = 1'b1;
    tick();
    check_cnt++;
    if (grant_out !== 2'b01 || ram_read_enable_out !== 1'b1 || ram_address_out !== 12'h0A5 ||
        done_out !== 1'b0)
      $display("[TB] FAIL read_access got grant=%b ren=%b addr=%h done=%b want 01 1 0a5 0",
               grant_out, ram_read_enable_out, ram_address_out, done_out);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (done_out !== 1'b1 || data_out !== 16'h1234 || grant_out !== 2'b01 ||
        ram_read_enable_out !== 1'b0)
      $display("[TB] FAIL read_done got done=%b data=%h grant=%b ren=%b want 1 1234 01 0",
               done_out, data_out, grant_out, ram_read_enable_out);
    else pass_cnt++;
    req_in[0] = 1'b0;
    tick();
    check_cnt++;
    if (grant_out !== 2'b00 || done_out !== 1'b0 || data_out !== 16'h1234)
      $display("[TB] FAIL read_idle got grant=%b done=%b data=%h want 00 0 1234",
               grant_out, done_out, data_out);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [1:0]  exp_grant [4];
    logic [15:0] exp_data  [4];
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    exp_data[0]  = 16'hAAAA; exp_data[1] = 16'h5555; exp_data[2] = 16'hAAAA; exp_data[3] = 16'h5555;
    do_reset();
    mem[12'h001]  = 16'hAAAA;
    mem[12'h002]  = 16'h5555;
    address_in[0] = 12'h001;
    address_in[1] = 12'h002;
    req_in        = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_cnt++;
      if (grant_out !== exp_grant[k] || done_out !== 1'b0)
        $display("[TB] FAIL contention_grant%0d got grant=%b done=%b want %b 0",
                 k, grant_out, done_out, exp_grant[k]);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (done_out !== 1'b1 || data_out !== exp_data[k])
        $display("[TB] FAIL contention_done%0d got done=%b data=%h want 1 %h",
                 k, done_out, data_out, exp_data[k]);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (grant_out !== 2'b00 || done_out !== 1'b0)
        $display("[TB] FAIL contention_idle%0d got grant=%b done=%b want 00 0",
                 k, grant_out, done_out);
      else pass_cnt++;
    end
    req_in = 2'b00;
  endtask

  task automatic test_write_read();
    int wen_base;
    do_reset();
    wen_base      = wen_total;
    mem[12'hFFF]  = 16'h0000;
    address_in[1] = 12'hFFF;
    data_in[1]    = 16'hBEEF;
    write_in[1]   = 1'b1;
    req_in[1]     = 1'b1;
    tick();
    check_cnt++;
    if (grant_out !== 2'b10 || ram_write_enable_out !== 1'b1 || ram_read_enable_out !== 1'b0 ||
        ram_address_out !== 12'hFFF || ram_data_out !== 16'hBEEF)
      $display("[TB] FAIL write_access got grant=%b wen=%b ren=%b addr=%h wdata=%h want 10 1 0 fff beef",
               grant_out, ram_write_enable_out, ram_read_enable_out, ram_address_out, ram_data_out);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (done_out !== 1'b1 || ram_write_enable_out !== 1'b0 || mem[12'hFFF] !== 16'hBEEF ||
        data_out !== 16'h0000)
      $display("[TB] FAIL write_done got done=%b wen=%b ram=%h data=%h want 1 0 beef 0000",
               done_out, ram_write_enable_out, mem[12'hFFF], data_out);
    else pass_cnt++;
    req_in[1]     = 1'b0;
    write_in[1]   = 1'b0;
    address_in[0] = 12'hFFF;
    req_in[0]     = 1'b1;
    tick();
    tick();
    check_cnt++;
    if (grant_out !== 2'b01 || ram_read_enable_out !== 1'b1)
      $display("[TB] FAIL readback_access got grant=%b ren=%b want 01 1",
               grant_out, ram_read_enable_out);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (done_out !== 1'b1 || data_out !== 16'hBEEF)
      $display("[TB] FAIL readback_data got done=%b data=%h want 1 beef", done_out, data_out);
    else pass_cnt++;
    req_in[0] = 1'b0;
    tick();
    check_cnt++;
    if (wen_total - wen_base !== 1)
      $display("[TB] FAIL write_enable_cycles got %0d want 1", wen_total - wen_base);
    else pass_cnt++;
  endtask

  task automatic test_locked_rmw();
    do_reset();
    mem[12'h010]  = 16'h0007;
    mem[12'h002]  = 16'h0022;
    address_in[0] = 12'h010;
    address_in[1] = 12'h002;
    lock_in[0]    = 1'b1;
    req_in        = 2'b11;
    tick();
    check_cnt++;
    if (grant_out !== 2'b01)
      $display("[TB] FAIL rmw_read_grant got %b want 01", grant_out);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (done_out !== 1'b1 || data_out !== 16'h0007)
      $display("[TB] FAIL rmw_read_done got done=%b data=%h want 1 0007", done_out, data_out);
    else pass_cnt++;
    write_in[0] = 1'b1;
    data_in[0]  = data_out + 16'h0001;
    tick();
    check_cnt++;
    if (grant_out !== 2'b01 || done_out !== 1'b0 || ram_write_enable_out !== 1'b0 ||
        ram_read_enable_out !== 1'b0)
      $display("[TB] FAIL rmw_locked got grant=%b done=%b wen=%b ren=%b want 01 0 0 0",
               grant_out, done_out, ram_write_enable_out, ram_read_enable_out);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (grant_out !== 2'b01 || ram_write_enable_out !== 1'b1 || ram_data_out !== 16'h0008)
      $display("[TB] FAIL rmw_write_access got grant=%b wen=%b wdata=%h want 01 1 0008",
               grant_out, ram_write_enable_out, ram_data_out);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (done_out !== 1'b1 || grant_out !== 2'b01 || mem[12'h010] !== 16'h0008)
      $display("[TB] FAIL rmw_write_done got done=%b grant=%b ram=%h want 1 01 0008",
               done_out, grant_out, mem[12'h010]);
    else pass_cnt++;
    req_in[0]   = 1'b0;
    lock_in[0]  = 1'b0;
    write_in[0] = 1'b0;
    tick();
    check_cnt++;
    if (grant_out !== 2'b00)
      $display("[TB] FAIL rmw_release got %b want 00", grant_out);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (grant_out !== 2'b10)
      $display("[TB] FAIL rmw_next_owner got %b want 10", grant_out);
    else pass_cnt++;
    req_in = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_lock_timeout();
    do_reset();
    address_in[0] = 12'h003;
    address_in[1] = 12'h004;
    lock_in[0]    = 1'b1;
    req_in        = 2'b11;
    tick();
    tick();
    check_cnt++;
    if (done_out !== 1'b1 || grant_out !== 2'b01)
      $display("[TB] FAIL timeout_first_done got done=%b grant=%b want 1 01", done_out, grant_out);
    else pass_cnt++;
    req_in[0] = 1'b0;
    // Fifteen idle cycles in LOCKED with the grant held.
    for (int i = 1; i <= 15; i++) begin
      tick();
      check_cnt++;
      if (grant_out !== 2'b01 || lock_timeout_out !== 1'b0)
        $display("[TB] FAIL timeout_hold%0d got grant=%b to=%b want 01 0",
                 i, grant_out, lock_timeout_out);
      else pass_cnt++;
    end
    tick();
    check_cnt++;
    if (lock_timeout_out !== 1'b1 || grant_out !== 2'b00)
      $display("[TB] FAIL timeout_pulse got to=%b grant=%b want 1 00", lock_timeout_out, grant_out);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (lock_timeout_out !== 1'b0 || grant_out !== 2'b10)
      $display("[TB] FAIL timeout_handover got to=%b grant=%b want 0 10", lock_timeout_out, grant_out);
    else pass_cnt++;
    req_in  = 2'b00;
    lock_in = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    mem[12'h020]  = 16'h1111;
    address_in[1] = 12'h020;
    data_in[1]    = 16'h2222;
    write_in[1]   = 1'b1;
    req_in[1]     = 1'b1;
    tick();
    check_cnt++;
    if (ram_write_enable_out !== 1'b1)
      $display("[TB] FAIL midwrite_access got wen=%b want 1", ram_write_enable_out);
    else pass_cnt++;
    reset_n_in = 1'b0;
    #1;
    check_cnt++;
    if (ram_write_enable_out !== 1'b0 || grant_out !== 2'b00 || done_out !== 1'b0)
      $display("[TB] FAIL midwrite_reset got wen=%b grant=%b done=%b want 0 00 0",
               ram_write_enable_out, grant_out, done_out);
    else pass_cnt++;
    req_in = 2'b00;
    tick();
    check_cnt++;
    if (mem[12'h020] !== 16'h1111 || data_out !== 16'h0000 || lock_timeout_out !== 1'b0)
      $display("[TB] FAIL midwrite_ram got ram=%h data=%h to=%b want 1111 0000 0",
               mem[12'h020], data_out, lock_timeout_out);
    else pass_cnt++;
    reset_n_in  = 1'b1;
    write_in[1] = 1'b0;
    tick();
  endtask

  initial begin
    check_cnt  = 0;
    pass_cnt   = 0;
    wen_total  = 0;
    reset_n_in = 1'b0;
    req_in     = '0;
    write_in   = '0;
    lock_in    = '0;
    address_in = '0;
    data_in    = '0;
    tick();
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_locked_rmw();
    test_lock_timeout();
    test_reset_mid_write();
    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
